// File: rtl/ejtag_pkg.sv
// Shared EJTAG trace definitions: RX lock FSM states, PCST codes, interval counter width.
package ejtag_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCK   = 2'd2
    } rx_state_e;

    localparam logic [2:0] PCST_STL  = 3'b000;
    localparam logic [2:0] PCST_JMP  = 3'b001;
    localparam logic [2:0] PCST_BRT  = 3'b010;
    localparam logic [2:0] PCST_EXP  = 3'b011;
    localparam logic [2:0] PCST_SEQ  = 3'b100;
    localparam logic [2:0] PCST_TSQ  = 3'b101;
    localparam logic [2:0] PCST_TST  = 3'b110;
    localparam logic [2:0] PCST_JMPS = 3'b111;

    localparam int INTV_W = 3;

endpackage

// File: rtl/ejtag_dclk_rx_fifo.sv
// Synchronous FIFO for captured trace words; accepts push and pop together even when full.
module ejtag_dclk_rx_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ejtag_dclk_rx.sv
// EJTAG PC-trace strobe receiver: cadence lock FSM, sticky flags, capture FIFO.
// Optional EJT_DCLK_RX_STALL_FILTER_EN drops STL words from the FIFO while still using them for lock.
module ejtag_dclk_rx
    import ejtag_pkg::*;
#(
    parameter int TPC_W    = 1,
    parameter int DEPTH    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       CFG_EJTNMINUS1,
    input  logic             EJT_DREN,
    input  logic [2:0]       EJT_PCST,
    input  logic [TPC_W-1:0] EJT_TPC,
    output logic             RX_VALID_R,
    output logic [TPC_W+2:0] RX_DATA,
    input  logic             RX_READY,
    output logic             RX_LOCK_R,
    output logic             RX_ERR_R,
    output logic             RX_OVF_R,
    input  logic             ERR_CLR
);
    localparam logic [3:0] LOCK_CNT_V = 4'(LOCK_CNT);

    rx_state_e         state_q, state_d;
    logic [INTV_W-1:0] intv_q, intv_d;
    logic [3:0]        match_cnt_q, match_cnt_d;
    logic [1:0]        cfgn_q, cfgn_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;

    logic match, late, cfg_chg, capture, push, pop, err_set, ovf_set;
    logic fifo_full, fifo_empty;

    assign match   = EJT_DREN & (intv_q == {1'b0, cfgn_q});
    assign late    = ~EJT_DREN & (({1'b0, intv_q} + 4'd1) > {2'b00, cfgn_q});
    assign cfg_chg = (CFG_EJTNMINUS1 != cfgn_q);
    assign capture = (state_q == ST_LOCK) & match;

`ifdef EJT_DCLK_RX_STALL_FILTER_EN
    assign push = capture & (EJT_PCST != PCST_STL);
`else
    assign push = capture;
`endif

    assign pop     = RX_VALID_R & RX_READY;
    assign ovf_set = push & fifo_full & ~pop;

    always_comb begin
        intv_d      = EJT_DREN ? '0 : ((intv_q == '1) ? intv_q : intv_q + 1'b1);
        cfgn_d      = CFG_EJTNMINUS1;
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        err_set     = 1'b0;
        // A configuration change restarts acquisition and outranks any cadence fault.
        if (cfg_chg) begin
            state_d     = ST_UNLOCK;
            match_cnt_d = '0;
        end else begin
            case (state_q)
                ST_UNLOCK: begin
                    if (EJT_DREN) begin
                        state_d     = ST_ACQ;
                        match_cnt_d = '0;
                    end
                end
                ST_ACQ: begin
                    if (match) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_q + 4'd1 == LOCK_CNT_V) state_d = ST_LOCK;
                    end else if (EJT_DREN | late) begin
                        state_d     = ST_UNLOCK;
                        match_cnt_d = '0;
                    end
                end
                ST_LOCK: begin
                    if ((EJT_DREN & ~match) | late) begin
                        state_d     = ST_UNLOCK;
                        match_cnt_d = '0;
                        err_set     = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_UNLOCK;
                    match_cnt_d = '0;
                end
            endcase
        end
        err_d = (err_q & ~ERR_CLR) | err_set;
        ovf_d = (ovf_q & ~ERR_CLR) | ovf_set;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_UNLOCK;
            intv_q      <= '0;
            match_cnt_q <= '0;
            cfgn_q      <= CFG_EJTNMINUS1;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            intv_q      <= intv_d;
            match_cnt_q <= match_cnt_d;
            cfgn_q      <= cfgn_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    ejtag_dclk_rx_fifo #(
        .WIDTH (TPC_W + 3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .din   ({EJT_PCST, EJT_TPC}),
        .dout  (RX_DATA),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign RX_VALID_R = ~fifo_empty;
    assign RX_LOCK_R  = (state_q == ST_LOCK);
    assign RX_ERR_R   = err_q;
    assign RX_OVF_R   = ovf_q;

endmodule

// File: tb/tb_ejtag_dclk_rx.sv
// Directed bench for ejtag_dclk_rx: lock, cadence errors, FIFO fill/overflow/drain, CFG change, reset.
module tb_ejtag_dclk_rx;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [1:0] CFG_EJTNMINUS1 = 2'b01;
    logic       EJT_DREN = 1'b0;
    logic [2:0] EJT_PCST = 3'b000;
    logic [0:0] EJT_TPC = 1'b0;
    logic       RX_VALID_R;
    logic [3:0] RX_DATA;
    logic       RX_READY = 1'b0;
    logic       RX_LOCK_R;
    logic       RX_ERR_R;
    logic       RX_OVF_R;
    logic       ERR_CLR = 1'b0;

    int total = 0;
    int bad = 0;

    logic [3:0] fill_words [9] = '{4'h3, 4'hA, 4'h5, 4'hC, 4'h2, 4'hF, 4'h6, 4'h9, 4'hE};
    logic [3:0] drain_words [8] = '{4'hA, 4'h5, 4'hC, 4'h2, 4'hF, 4'h6, 4'h9, 4'h4};

    ejtag_dclk_rx #(
        .TPC_W    (1),
        .DEPTH    (8),
        .LOCK_CNT (4)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .CFG_EJTNMINUS1 (CFG_EJTNMINUS1),
        .EJT_DREN       (EJT_DREN),
        .EJT_PCST       (EJT_PCST),
        .EJT_TPC        (EJT_TPC),
        .RX_VALID_R     (RX_VALID_R),
        .RX_DATA        (RX_DATA),
        .RX_READY       (RX_READY),
        .RX_LOCK_R      (RX_LOCK_R),
        .RX_ERR_R       (RX_ERR_R),
        .RX_OVF_R       (RX_OVF_R),
        .ERR_CLR        (ERR_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] d);
        EJT_DREN = 1'b1;
        EJT_PCST = d[3:1];
        EJT_TPC  = d[0:0];
        tick();
        EJT_DREN = 1'b0;
    endtask

    task automatic idle(input int n);
        EJT_DREN = 1'b0;
        repeat (n) tick();
    endtask

    // Five strobes spaced n cycles apart: one to start measuring, four matches to lock.
    task automatic lock_seq(input int n, input logic [3:0] d);
        repeat (4) begin
            strobe(d);
            idle(n - 1);
        end
        strobe(d);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_valid", RX_VALID_R, 0);
        chk("rst_data", RX_DATA, 0);
        chk("rst_lock", RX_LOCK_R, 0);
        chk("rst_err", RX_ERR_R, 0);
        chk("rst_ovf", RX_OVF_R, 0);
        RESET = 1'b0;

        // Test 1: N=2 lock after 5th strobe
        strobe(4'h2); idle(1);
        strobe(4'h2); idle(1);
        strobe(4'h2); idle(1);
        strobe(4'h2);
        chk("t1_lock_after4", RX_LOCK_R, 0);
        idle(1);
        strobe(4'h2);
        chk("t1_lock_after5", RX_LOCK_R, 1);
        chk("t1_err", RX_ERR_R, 0);
        chk("t1_no_capture_acq", RX_VALID_R, 0);
        idle(1);
        strobe(4'hB);
        chk("t1_cap_valid", RX_VALID_R, 1);
        chk("t1_cap_data", RX_DATA, 4'hB);
        RX_READY = 1'b1;
        idle(1);
        RX_READY = 1'b0;
        chk("t1_pop_empty", RX_VALID_R, 0);

        // Test 2: N=3, late strobe error, clear, relock, early strobe
        CFG_EJTNMINUS1 = 2'b10;
        idle(1);
        chk("t2_cfg_unlock", RX_LOCK_R, 0);
        chk("t2_cfg_noerr", RX_ERR_R, 0);
        lock_seq(3, 4'h2);
        chk("t2_lock", RX_LOCK_R, 1);
        idle(2);
        chk("t2_lock_hold", RX_LOCK_R, 1);
        chk("t2_err_before_late", RX_ERR_R, 0);
        idle(1);
        chk("t2_late_unlock", RX_LOCK_R, 0);
        chk("t2_late_err", RX_ERR_R, 1);
        chk("t2_late_nocap", RX_VALID_R, 0);
        ERR_CLR = 1'b1;
        idle(1);
        ERR_CLR = 1'b0;
        chk("t2_err_clr", RX_ERR_R, 0);
        lock_seq(3, 4'h2);
        chk("t2_relock", RX_LOCK_R, 1);
        chk("t2_relock_noerr", RX_ERR_R, 0);
        idle(1);
        strobe(4'h7);
        chk("t2_early_unlock", RX_LOCK_R, 0);
        chk("t2_early_err", RX_ERR_R, 1);
        chk("t2_early_nocap", RX_VALID_R, 0);
        lock_seq(3, 4'h2);
        chk("t2_relock2", RX_LOCK_R, 1);
        chk("t2_err_sticky", RX_ERR_R, 1);
        idle(1);
        ERR_CLR = 1'b1;
        strobe(4'h7);
        ERR_CLR = 1'b0;
        chk("t2_err_set_wins", RX_ERR_R, 1);
        ERR_CLR = 1'b1;
        idle(1);
        ERR_CLR = 1'b0;
        chk("t2_err_clr2", RX_ERR_R, 0);

        // Test 3: N=1, fill FIFO with ready low, overflow on 9th
        CFG_EJTNMINUS1 = 2'b00;
        idle(1);
        chk("t3_cfg_unlock", RX_LOCK_R, 0);
        lock_seq(1, 4'h2);
        chk("t3_lock", RX_LOCK_R, 1);
        chk("t3_empty", RX_VALID_R, 0);
        for (int k = 0; k < 8; k++) strobe(fill_words[k]);
        chk("t3_full_valid", RX_VALID_R, 1);
        chk("t3_full_head", RX_DATA, fill_words[0]);
        chk("t3_full_noovf", RX_OVF_R, 0);
        strobe(fill_words[8]);
        chk("t3_ovf", RX_OVF_R, 1);
        chk("t3_head_stable", RX_DATA, fill_words[0]);
        chk("t3_lock_hold", RX_LOCK_R, 1);
        ERR_CLR = 1'b1;
        strobe(4'h8);
        chk("t3_ovf_set_wins", RX_OVF_R, 1);

        // Test 4: full FIFO, push and pop together
        RX_READY = 1'b1;
        strobe(4'h4);
        ERR_CLR  = 1'b0;
        RX_READY = 1'b0;
        chk("t4_noovf", RX_OVF_R, 0);
        chk("t4_head_adv", RX_DATA, 4'hA);
        CFG_EJTNMINUS1 = 2'b01;
        idle(1);
        chk("t4_cfg_unlock", RX_LOCK_R, 0);
        chk("t4_cfg_noerr", RX_ERR_R, 0);
        RX_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_drain_valid%0d", i), RX_VALID_R, 1);
            chk($sformatf("t4_drain_data%0d", i), RX_DATA, drain_words[i]);
            tick();
        end
        RX_READY = 1'b0;
        chk("t4_drained", RX_VALID_R, 0);

        // Test 5: N=4 lock, capture, CFG change keeps FIFO
        CFG_EJTNMINUS1 = 2'b11;
        idle(1);
        lock_seq(4, 4'h2);
        chk("t5_lock", RX_LOCK_R, 1);
        idle(3);
        strobe(4'hD);
        chk("t5_cap1", RX_DATA, 4'hD);
        idle(3);
        strobe(4'h7);
        chk("t5_head_stable", RX_DATA, 4'hD);
        CFG_EJTNMINUS1 = 2'b01;
        idle(1);
        chk("t5_cfg_unlock", RX_LOCK_R, 0);
        chk("t5_cfg_noerr", RX_ERR_R, 0);
        chk("t5_fifo_valid", RX_VALID_R, 1);
        chk("t5_fifo_head", RX_DATA, 4'hD);
        RX_READY = 1'b1;
        tick();
        RX_READY = 1'b0;
        chk("t5_second", RX_DATA, 4'h7);

        // Reset mid-stream flushes the FIFO
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
        chk("rst2_valid", RX_VALID_R, 0);
        chk("rst2_data", RX_DATA, 0);
        chk("rst2_lock", RX_LOCK_R, 0);

`ifdef EJT_DCLK_RX_STALL_FILTER_EN
        // Test 6: STL words are not stored but keep lock
        lock_seq(2, 4'h8);
        chk("t6_lock", RX_LOCK_R, 1);
        idle(1);
        strobe(4'h1);
        chk("t6_stl_dropped", RX_VALID_R, 0);
        chk("t6_stl_lock", RX_LOCK_R, 1);
        idle(1);
        strobe(4'h9);
        chk("t6_seq1", RX_DATA, 4'h9);
        idle(1);
        strobe(4'h0);
        idle(1);
        strobe(4'h8);
        chk("t6_lock_hold", RX_LOCK_R, 1);
        chk("t6_noovf", RX_OVF_R, 0);
        RX_READY = 1'b1;
        tick();
        chk("t6_seq2", RX_DATA, 4'h8);
        tick();
        RX_READY = 1'b0;
        chk("t6_empty", RX_VALID_R, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
